an_tone_ds_mc: RTL

AN_TONE_DS_MC -- requirements
Module: an_tone_ds_mc

---
 rtl/an_tone_ds_mc.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/an_tone_ds_mc.sv
// an_tone_ds_mc: multi-channel triangle tone generator with 1-bit
// delta-sigma outputs per channel, a square-wave output per channel and a
// delta-sigma output of the averaged channel mix.
//
// Per channel: phase accumulator PH += INC, triangle T folded from PH,
// sample S = (T * LVL) >> C_DAT_W, first-order modulator on S.
// Registers INC / LVL / PHASE are written through a simple strobe port.
//
// Optional build macro AN_TONE_DS_MC_DITHER_EN: adds a 16-bit LFSR whose
// bit 0 dithers every nonzero modulator input.
module an_tone_ds_mc #(
  parameter int C_CK_Fs   = 135_000_000,
  parameter int C_TONE_Fs = 440,
  parameter int C_CH_N    = 2,
  parameter int C_PHASE_W = 24,
  parameter int C_DAT_W   = 12
) (
  input  logic                 CK_i,
  input  logic                 XARST_i,
  input  logic                 WR_i,
  input  logic [2:0]           WR_CH_i,
  input  logic [1:0]           WR_SEL_i,
  input  logic [C_PHASE_W-1:0] WR_DAT_i,
  output logic                 WR_ACK_o,
  output logic                 ERR_o,
  output logic [C_CH_N-1:0]    DS_o,
  output logic [C_CH_N-1:0]    SQ_o,
  output logic                 DS_MIX_o
);

  localparam int C_MIX_SH = $clog2(C_CH_N);
  localparam int C_SUM_W  = C_DAT_W + C_MIX_SH;
  localparam int C_PRD_W  = 2 * C_DAT_W + 1;

  // Reset increment: round(C_TONE_Fs * 2^C_PHASE_W / C_CK_Fs), in 64 bits
  // so the numerator cannot overflow for realistic phase widths.
  localparam logic [63:0] C_INC_RND =
    (64'(C_TONE_Fs) * (64'd1 << C_PHASE_W) + 64'(C_CK_Fs) / 64'd2) / 64'(C_CK_Fs);
  localparam logic [C_PHASE_W-1:0] C_INC_RST = C_INC_RND[C_PHASE_W-1:0];
  localparam logic [C_DAT_W:0]     C_LVL_MAX = {1'b1, {C_DAT_W{1'b0}}};

  typedef enum logic [1:0] {
    SEL_INC = 2'd0,
    SEL_LVL = 2'd1,
    SEL_PH  = 2'd2,
    SEL_BAD = 2'd3
  } sel_e;

  // Channel registers
  logic [C_PHASE_W-1:0] r_ph  [C_CH_N];
  logic [C_PHASE_W-1:0] r_inc [C_CH_N];
  logic [C_DAT_W:0]     r_lvl [C_CH_N];
  logic [C_DAT_W-1:0]   r_s   [C_CH_N];
  logic [C_DAT_W:0]     r_acc [C_CH_N];
  logic [C_CH_N-1:0]    r_ds;
  logic [C_CH_N-1:0]    r_sq;

  // Mix path and write handshake registers
  logic [C_DAT_W-1:0]   r_mix;
  logic [C_DAT_W:0]     r_macc;
  logic                 r_ds_mix;
  logic                 r_ack;
  logic                 r_err;

  // Combinational nets
  sel_e                 w_sel;
  logic                 w_wr_ok;
  logic                 w_wr_bad;
  logic [C_CH_N-1:0]    w_hit;
  logic [C_DAT_W:0]     w_lvl_dat;
  logic [C_DAT_W-1:0]   w_u   [C_CH_N];
  logic [C_DAT_W-1:0]   w_t   [C_CH_N];
  logic [C_DAT_W-1:0]   w_s   [C_CH_N];
  logic [C_SUM_W-1:0]   w_mix_sum;
  logic [C_DAT_W-1:0]   w_mix;
  logic [C_DAT_W:0]     w_mod_in [C_CH_N];
  logic [C_DAT_W:0]     w_mix_in;

  assign w_sel = sel_e'(WR_SEL_i);

  // Write decode: accept when the channel exists and the selector is legal.
  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_wr_ok   = WR_i && (int'(WR_CH_i) < C_CH_N) && (w_sel != SEL_BAD);
    w_wr_bad  = WR_i && !w_wr_ok;
    w_lvl_dat = (WR_DAT_i[C_DAT_W:0] > C_LVL_MAX) ? C_LVL_MAX : WR_DAT_i[C_DAT_W:0];
    w_hit     = '0;
    for (int c = 0; c < C_CH_N; c++) begin
      w_hit[c] = w_wr_ok && (int'(WR_CH_i) == c);
    end
  end

  // Triangle fold and amplitude scaling of each channel's phase.
  always_comb begin
    for (int c = 0; c < C_CH_N; c++) begin
      w_u[c] = r_ph[c][C_PHASE_W-2 -: C_DAT_W];
      w_t[c] = r_ph[c][C_PHASE_W-1] ? ~w_u[c] : w_u[c];
      w_s[c] = C_DAT_W'((C_PRD_W'(w_t[c]) * C_PRD_W'(r_lvl[c])) >> C_DAT_W);
    end
  end

  // Average of the registered channel samples feeding the mix modulator.
  always_comb begin
    w_mix_sum = '0;
    for (int c = 0; c < C_CH_N; c++) begin
      w_mix_sum = w_mix_sum + C_SUM_W'(r_s[c]);
    end
    w_mix = C_DAT_W'(w_mix_sum >> C_MIX_SH);
  end

`ifdef AN_TONE_DS_MC_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_dith;

  assign w_dith = r_lfsr[0];

  // Maximal-length LFSR x^16+x^14+x^13+x^11+1, stepping every cycle.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  // Modulator inputs: add the dither bit only to nonzero samples, so a
  // silent channel stays silent.
  always_comb begin
    for (int c = 0; c < C_CH_N; c++) begin
      w_mod_in[c] = {1'b0, r_s[c]} +
                    ((r_s[c] != '0) ? {{C_DAT_W{1'b0}}, w_dith} : '0);
    end
    w_mix_in = {1'b0, r_mix} + ((r_mix != '0) ? {{C_DAT_W{1'b0}}, w_dith} : '0);
  end
`else
  // Modulator inputs are the plain samples.
  always_comb begin
    for (int c = 0; c < C_CH_N; c++) begin
      w_mod_in[c] = {1'b0, r_s[c]};
    end
    w_mix_in = {1'b0, r_mix};
  end
`endif

  // Configuration registers and phase accumulators; a PHASE write wins
  // over that cycle's accumulate.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      // NOTE: these small register arrays hold architectural state, so they are reset like any flop.
      for (int c = 0; c < C_CH_N; c++) begin
        r_ph[c]  <= '0;
        r_inc[c] <= C_INC_RST;
        r_lvl[c] <= C_LVL_MAX;
      end
    end else begin
      for (int c = 0; c < C_CH_N; c++) begin
        if (w_hit[c] && (w_sel == SEL_PH)) begin
          r_ph[c] <= WR_DAT_i;
        end else begin
          r_ph[c] <= r_ph[c] + r_inc[c];
        end
        if (w_hit[c] && (w_sel == SEL_INC)) begin
          r_inc[c] <= WR_DAT_i;
        end
        if (w_hit[c] && (w_sel == SEL_LVL)) begin
          r_lvl[c] <= w_lvl_dat;
        end
      end
    end
  end

  // Sample, modulator and output pipeline per channel plus the mix path.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      for (int c = 0; c < C_CH_N; c++) begin
        r_s[c]   <= '0;
        r_acc[c] <= '0;
      end
      r_ds     <= '0;
      r_sq     <= '0;
      r_mix    <= '0;
      r_macc   <= '0;
      r_ds_mix <= 1'b0;
    end else begin
      for (int c = 0; c < C_CH_N; c++) begin
        r_sq[c]  <= r_ph[c][C_PHASE_W-1];
        r_s[c]   <= w_s[c];
        r_acc[c] <= {1'b0, r_acc[c][C_DAT_W-1:0]} + w_mod_in[c];
        r_ds[c]  <= r_acc[c][C_DAT_W];
      end
      r_mix    <= w_mix;
      r_macc   <= {1'b0, r_macc[C_DAT_W-1:0]} + w_mix_in;
      r_ds_mix <= r_macc[C_DAT_W];
    end
  end

  // Write handshake: one-cycle pulses following the write cycle; reset
  // drops any write still in flight.
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_wr_ok;
      r_err <= w_wr_bad;
    end
  end

  assign WR_ACK_o = r_ack;
  assign ERR_o    = r_err;
  assign DS_o     = r_ds;
  assign SQ_o     = r_sq;
  assign DS_MIX_o = r_ds_mix;

endmodule
